// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel window sequencer.
package sobel_pkg;

   localparam int SOBEL_PIC_WIDTH  = 640;
   localparam int SOBEL_PIC_HEIGHT = 480;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DRAIN
   } state_t;

   typedef struct packed {
      logic live;
      logic interior;
   } tag_t;

   localparam tag_t TAG_NULL = '{live: 1'b0, interior: 1'b0};

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel-stream handshake, line-buffer control and result flags of the Sobel window sequencer.
interface sobel_window_ctrl_if #(
   parameter int AW = 10
);
   logic          pix_valid;
   logic          pix_sof;
   logic          lb_wr_en;
   logic          lb_rd_en;
   logic [AW-1:0] lb_addr;
   logic          dp_valid;
   logic          out_valid;
   logic          out_border;
   logic          frame_done;
   logic          busy;
   logic          err_sof;

   modport master (
      output pix_valid, pix_sof,
      input  lb_wr_en, lb_rd_en, lb_addr, dp_valid, out_valid, out_border,
             frame_done, busy, err_sof
   );

   modport slave (
      input  pix_valid, pix_sof,
      output lb_wr_en, lb_rd_en, lb_addr, dp_valid, out_valid, out_border,
             frame_done, busy, err_sof
   );
endinterface

// File: rtl/sobel_tag_pipe.sv
// LAT-deep position-tag shift register; advances with the datapath and flushes to null.
module sobel_tag_pipe
   import sobel_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic flush_i,
   input  tag_t tag_i,
   output tag_t tag_o
);

   tag_t pipe_q [LAT];

   // NOTE: every stage is reset, because a stale live tag after reset would raise a spurious result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) pipe_q[i] <= TAG_NULL;
      end else if (en_i) begin
         pipe_q[0] <= tag_i;
         for (int i = 1; i < LAT; i++) pipe_q[i] <= flush_i ? TAG_NULL : pipe_q[i-1];
      end else if (flush_i) begin
         for (int i = 0; i < LAT; i++) pipe_q[i] <= TAG_NULL;
      end
   end

   assign tag_o = pipe_q[LAT-1];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster sequencer for the 3x3 Sobel datapath: position tracking, line-buffer control, drain.
// Define SOBEL_WIN_BORDER_EN to flag every result and mark border positions via out_border.
module sobel_window_ctrl
   import sobel_pkg::*;
#(
   parameter int PIC_WIDTH  = SOBEL_PIC_WIDTH,
   parameter int PIC_HEIGHT = SOBEL_PIC_HEIGHT,
   parameter int LAT        = 2,
   parameter int AW         = 10
) (
   input logic          clk,
   input logic          rst_n,
   sobel_window_ctrl_if.slave bus
);

   localparam int CW = $clog2(PIC_WIDTH);
   localparam int RW = $clog2(PIC_HEIGHT);
   localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d, pcol;
   logic [RW-1:0] row_q, row_d, prow;
   logic [DW-1:0] drain_q, drain_d;
   logic          done_q, done_d;
   logic          dpv_q;
   logic          start, restart, accept, last_pix, drain_end, dp_valid;
   tag_t          push_tag, tag_out;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      start     = bus.pix_valid & bus.pix_sof;
      restart   = start & (state_q != IDLE);
      accept    = bus.pix_valid & (bus.pix_sof | (state_q == ACTIVE));
      pcol      = start ? '0 : col_q;
      prow      = start ? '0 : row_q;
      last_pix  = (pcol == CW'(PIC_WIDTH - 1)) && (prow == RW'(PIC_HEIGHT - 1));
      drain_end = (state_q == DRAIN) && (drain_q == DW'(LAT - 1));

      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      drain_d = drain_q;
      done_d  = 1'b0;

      if (state_q == DRAIN) begin
         drain_d = drain_q + 1'b1;
         if (drain_end) begin
            state_d = IDLE;
            drain_d = '0;
            done_d  = 1'b1;
         end
      end

      // An accepted pixel overrides the drain: a restart abandons the frame without frame_done.
      if (accept) begin
         drain_d = '0;
         done_d  = 1'b0;
         if (last_pix) begin
            state_d = DRAIN;
            col_d   = '0;
            row_d   = '0;
         end else begin
            state_d = ACTIVE;
            if (pcol == CW'(PIC_WIDTH - 1)) begin
               col_d = '0;
               row_d = prow + 1'b1;
            end else begin
               col_d = pcol + 1'b1;
               row_d = prow;
            end
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         drain_q <= '0;
         done_q  <= 1'b0;
         dpv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         drain_q <= drain_d;
         done_q  <= done_d;
         dpv_q   <= dp_valid;
      end
   end

   assign dp_valid          = accept | (state_q == DRAIN);
   assign push_tag.live     = accept;
   assign push_tag.interior = accept & (pcol >= CW'(2)) & (prow >= RW'(2));

   sobel_tag_pipe #(.LAT(LAT)) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (dp_valid),
      .flush_i (restart),
      .tag_i   (push_tag),
      .tag_o   (tag_out)
   );

   assign bus.lb_wr_en   = accept;
   assign bus.lb_rd_en   = accept;
   assign bus.lb_addr    = accept ? AW'(pcol) : '0;
   assign bus.dp_valid   = dp_valid;
   assign bus.frame_done = done_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.err_sof    = restart;

   // Results are gated by the registered dp_valid so they never persist across input gaps.
`ifdef SOBEL_WIN_BORDER_EN
   assign bus.out_valid  = dpv_q & tag_out.live;
   assign bus.out_border = dpv_q & tag_out.live & ~tag_out.interior;
`else
   assign bus.out_valid  = dpv_q & tag_out.live & tag_out.interior;
   assign bus.out_border = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl: step-indexed tag model plus literal scenario checks.
module tb_sobel_window_ctrl;

   localparam int W   = 8;
   localparam int H   = 6;
   localparam int LAT = 2;
   localparam int AW  = 10;
`ifdef SOBEL_WIN_BORDER_EN
   localparam bit BORDER = 1'b1;
`else
   localparam bit BORDER = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sobel_window_ctrl_if #(.AW(AW)) bus ();

   sobel_window_ctrl #(
      .PIC_WIDTH  (W),
      .PIC_HEIGHT (H),
      .LAT        (LAT),
      .AW         (AW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: frame position plus a history of tags indexed by datapath step.
   bit       m_busy, m_drain, m_outv, m_outb, m_done;
   int       m_left, m_col, m_row, flush_at;
   bit [1:0] hist [$];

   int cyc;
   int cnt_out, cnt_bord, cnt_done, cnt_err, cnt_wr, cnt_dp, cnt_busy;
   int first_out, first_bord, t00, t22, t_last, t_done;
   int addr_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_drain = 0; m_left = 0; m_col = 0; m_row = 0;
      m_outv = 0; m_outb = 0; m_done = 0; flush_at = 0;
      hist.delete();
   endtask

   task automatic clear_counts();
      cnt_out = 0; cnt_bord = 0; cnt_done = 0; cnt_err = 0; cnt_wr = 0; cnt_dp = 0; cnt_busy = 0;
      first_out = -1; first_bord = 0; t00 = 0; t22 = 0; t_last = 0; t_done = 0;
      addr_q.delete();
   endtask

   task automatic step(input bit v, input bit s);
      bit start, err, acc, dp;
      int pc, pr, src;
      bit [1:0] tg;
      logic [7:0] ev, av;
      @(negedge clk);
      bus.pix_valid = v;
      bus.pix_sof   = s;
      #1;
      start = v && s;
      err   = start && m_busy;
      acc   = v && (s || (m_busy && !m_drain));
      dp    = acc || m_drain;
      pc    = start ? 0 : m_col;
      pr    = start ? 0 : m_row;

      ev = {acc, acc, dp, m_busy, err, m_outv, m_outb, m_done};
      av = {bus.lb_wr_en, bus.lb_rd_en, bus.dp_valid, bus.busy, bus.err_sof,
            bus.out_valid, bus.out_border, bus.frame_done};
      check("cycle_outputs", 32'(av), 32'(ev));
      if (acc) check("lb_addr", 32'(bus.lb_addr), pc);

      if (bus.out_valid === 1'b1) begin
         cnt_out++;
         if (first_out < 0) begin
            first_out  = cyc;
            first_bord = int'(bus.out_border);
         end
      end
      if (bus.out_border === 1'b1) cnt_bord++;
      if (bus.frame_done === 1'b1) begin cnt_done++; t_done = cyc; end
      if (bus.err_sof === 1'b1) cnt_err++;
      if (bus.lb_wr_en === 1'b1) begin cnt_wr++; addr_q.push_back(int'(bus.lb_addr)); end
      if (bus.dp_valid === 1'b1) cnt_dp++;
      if (bus.busy === 1'b1) cnt_busy++;

      m_outv = 0; m_outb = 0; m_done = 0;
      if (dp) begin
         if (start) flush_at = hist.size();
         tg = acc ? {1'b1, (pc >= 2 && pr >= 2)} : 2'b00;
         hist.push_back(tg);
         src = hist.size() - LAT;
         if (src >= flush_at) begin
            m_outv = hist[src][1] && (BORDER || hist[src][0]);
            m_outb = BORDER && hist[src][1] && !hist[src][0];
         end
      end
      if (m_drain && !start) begin
         m_left--;
         if (m_left == 0) begin m_drain = 0; m_busy = 0; m_done = 1; end
      end
      if (acc) begin
         if (pc == 0 && pr == 0) t00 = cyc;
         if (pc == 2 && pr == 2) t22 = cyc;
         m_busy  = 1;
         m_drain = 0;
         if (pc == W-1 && pr == H-1) begin
            m_drain = 1; m_left = LAT; m_col = 0; m_row = 0; t_last = cyc;
         end else if (pc == W-1) begin
            m_col = 0; m_row = pr + 1;
         end else begin
            m_col = pc + 1; m_row = pr;
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      logic [9:0] outs;
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      rst_n = 1'b0;
      #1;
      outs = {bus.lb_wr_en, bus.lb_rd_en, bus.dp_valid, bus.out_valid, bus.out_border,
              bus.frame_done, bus.busy, bus.err_sof, 2'b00};
      check("reset_outputs", 32'(outs), 0);
      check("reset_lb_addr", 32'(bus.lb_addr), 0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic send_frame(input bit toggle);
      for (int i = 0; i < W*H; i++) begin
         step(1'b1, i == 0);
         if (toggle) step(1'b0, 1'b0);
      end
   endtask

   initial begin
      int bad;
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      cyc = 0;
      model_reset();
      clear_counts();
      do_reset();

      // Pixels without start-of-frame in IDLE are ignored.
      clear_counts();
      repeat (5) step(1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0);
      check("idle_wr_en", cnt_wr, 0);
      check("idle_dp_valid", cnt_dp, 0);
      check("idle_busy", cnt_busy, 0);

      // Continuous frame.
      clear_counts();
      send_frame(1'b0);
      repeat (6) step(1'b0, 1'b0);
      check("cont_outs", cnt_out, BORDER ? 48 : 24);
      check("cont_border", cnt_bord, BORDER ? 24 : 0);
      check("cont_done", cnt_done, 1);
      check("cont_first_lat", first_out - (BORDER ? t00 : t22), 2);
      check("cont_first_border", first_bord, BORDER ? 1 : 0);
      check("cont_done_lat", t_done - t_last, 3);
      check("cont_busy_after", 32'(bus.busy), 0);

      // pix_valid toggling every other cycle.
      clear_counts();
      send_frame(1'b1);
      repeat (6) step(1'b0, 1'b0);
      check("tog_outs", cnt_out, BORDER ? 48 : 24);
      check("tog_border", cnt_bord, BORDER ? 24 : 0);
      check("tog_done", cnt_done, 1);
      bad = 0;
      foreach (addr_q[i]) if (addr_q[i] != i % W) bad++;
      check("tog_addr_len", addr_q.size(), W*H);
      check("tog_addr_seq", bad, 0);

      // Restart at pixel 20, followed by a complete frame.
      clear_counts();
      for (int i = 0; i < 20; i++) step(1'b1, i == 0);
      send_frame(1'b0);
      repeat (6) step(1'b0, 1'b0);
      check("abort_err", cnt_err, 1);
      check("abort_done", cnt_done, 1);
      check("abort_outs", cnt_out, BORDER ? 67 : 25);
      check("abort_border", cnt_bord, BORDER ? 42 : 0);

      // Reset asserted during DRAIN, then a fresh frame.
      clear_counts();
      send_frame(1'b0);
      @(posedge clk);
      #2;
      check("drain_busy", 32'(bus.busy), 1);
      check("drain_dp_valid", 32'(bus.dp_valid), 1);
      do_reset();
      clear_counts();
      send_frame(1'b0);
      repeat (6) step(1'b0, 1'b0);
      check("rst_outs", cnt_out, BORDER ? 48 : 24);
      check("rst_done", cnt_done, 1);
      check("rst_first_lat", first_out - (BORDER ? t00 : t22), 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
